valve_responder: RTL and testbench

VALVE_RESPONDER -- requirements
Module: valve_responder

---
 rtl/valve_responder.sv | 104 ++++++++++
 tb/tb_valve_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/valve_responder.sv
// Irrigation valve responder: arm/run/done/fault sequencer with a
// debounced humidity flag returned to the process controller.
module valve_responder #(
  parameter int RUN_CYCLES  = 8,
  parameter int ARM_TIMEOUT = 15,
  parameter int DEB_CYCLES  = 3
) (
  input  logic Ck,
  input  logic Clr,
  input  logic St,
  input  logic O5,
  input  logic O6,
  input  logic Hraw,
  output logic H1,
  output logic RC,
  output logic R
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam logic [7:0] ARM_LOAD = 8'(ARM_TIMEOUT);
  localparam logic [7:0] RUN_LOAD = 8'(RUN_CYCLES - 1);
  localparam logic [7:0] DEB_LIM  = 8'(DEB_CYCLES);

  logic [2:0] r_state;
  logic [7:0] r_arm_cnt;
  logic [7:0] r_run_cnt;
  logic [7:0] r_deb_cnt;
  logic       r_h1;
  logic       w_diff;

  assign w_diff = (Hraw != r_h1);

  // Debouncer is free-running, independent of the sequencer state.
  always_ff @(posedge Ck) begin
    if (Clr) begin
      r_h1      <= 1'b0;
      r_deb_cnt <= '0;
    end else if (!w_diff) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_LIM) begin
      r_h1      <= Hraw;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 8'd1;
    end
  end

  always_ff @(posedge Ck) begin
    if (Clr) begin
      r_state   <= S_IDLE;
      r_arm_cnt <= '0;
      r_run_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (St && O5) begin
            r_state   <= S_ARM;
            r_arm_cnt <= ARM_LOAD;
          end
        end
        S_ARM: begin
          if (!O5) begin
            r_state <= S_FAULT;
          end else if (O6) begin
            r_state   <= S_RUN;
            r_run_cnt <= RUN_LOAD;
          end else if (r_arm_cnt == 8'd0) begin
            r_state <= S_FAULT;
          end else begin
            r_arm_cnt <= r_arm_cnt - 8'd1;
          end
        end
        S_RUN: begin
          if (!O5 || !O6) begin
            r_state <= S_FAULT;
          end else if (r_h1) begin
            r_state <= S_DONE;
          end else if (r_run_cnt == 8'd0) begin
            r_state <= S_DONE;
          end else begin
            r_run_cnt <= r_run_cnt - 8'd1;
          end
        end
        S_DONE: begin
          if (!O5 && !O6) r_state <= S_IDLE;
        end
        S_FAULT: begin
          if (!St && !O5) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign H1 = r_h1;
  assign RC = (r_state == S_DONE);
  assign R  = (r_state == S_FAULT);

endmodule

// File: tb/tb_valve_responder.sv
// Bench for valve_responder: directed scenarios with literal timing
// expectations plus randomized traffic against a cycle-level model.
module tb_valve_responder;

  localparam int RUNC = 8;
  localparam int ARMT = 15;
  localparam int DEBC = 3;

  logic Ck, Clr, St, O5, O6, Hraw;
  logic H1, RC, R;

  int checks   = 0;
  int failures = 0;

  valve_responder #(
    .RUN_CYCLES (RUNC),
    .ARM_TIMEOUT(ARMT),
    .DEB_CYCLES (DEBC)
  ) dut (
    .Ck  (Ck),
    .Clr (Clr),
    .St  (St),
    .O5  (O5),
    .O6  (O6),
    .Hraw(Hraw),
    .H1  (H1),
    .RC  (RC),
    .R   (R)
  );

  initial Ck = 1'b0;
  always #5 Ck = ~Ck;

  // Model: phase name, cycles elapsed in phase, humidity flag and
  // length of the current run of samples disagreeing with it.
  typedef enum int {P_IDLE, P_ARM, P_RUN, P_DONE, P_FAULT} phase_t;
  phase_t m_ph;
  int     m_el;
  bit     m_h1;
  int     m_streak;
  bit     m_valid = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    phase_t nph;
    int     nel;
    bit     nh1;
    int     nstr;
    nph  = m_ph;
    nel  = m_el;
    nh1  = m_h1;
    nstr = m_streak;
    if (Clr) begin
      nph  = P_IDLE;
      nel  = 0;
      nh1  = 0;
      nstr = 0;
    end else begin
      if (Hraw == m_h1) nstr = 0;
      else if (m_streak == DEBC) begin
        nh1  = Hraw;
        nstr = 0;
      end else nstr = m_streak + 1;
      case (m_ph)
        P_IDLE: if (St && O5) begin nph = P_ARM; nel = 0; end
        P_ARM: begin
          if (!O5) nph = P_FAULT;
          else if (O6) begin nph = P_RUN; nel = 0; end
          else if (m_el >= ARMT) nph = P_FAULT;
          else nel = m_el + 1;
        end
        P_RUN: begin
          if (!O5 || !O6) nph = P_FAULT;
          else if (m_h1) nph = P_DONE;
          else if (m_el >= RUNC - 1) nph = P_DONE;
          else nel = m_el + 1;
        end
        P_DONE:  if (!O5 && !O6) nph = P_IDLE;
        P_FAULT: if (!St && !O5) nph = P_IDLE;
        default: nph = P_IDLE;
      endcase
    end
    if (Clr) m_valid = 1;
    @(posedge Ck);
    #1;
    m_ph     = nph;
    m_el     = nel;
    m_h1     = nh1;
    m_streak = nstr;
    if (m_valid) begin
      chk("model_RC", 32'(RC), 32'(m_ph == P_DONE));
      chk("model_R",  32'(R),  32'(m_ph == P_FAULT));
      chk("model_H1", 32'(H1), 32'(m_h1));
    end
  endtask

  task automatic idle_inputs();
    St = 0; O5 = 0; O6 = 0;
  endtask

  task automatic enter_run();
    St = 1; O5 = 1; O6 = 0;
    tick();
    O6 = 1;
    tick();
  endtask

  int n;

  initial begin
    m_ph = P_IDLE; m_el = 0; m_h1 = 0; m_streak = 0;
    Clr = 1; Hraw = 0;
    idle_inputs();
    tick();
    tick();
    chk("rst_RC", 32'(RC), 0);
    chk("rst_R",  32'(R),  0);
    chk("rst_H1", 32'(H1), 0);
    Clr = 0;
    tick();

    // normal run
    enter_run();
    n = 0;
    while (!RC && n < 40) begin tick(); n++; end
    chk("run_len", n, RUNC);
    repeat (3) tick();
    chk("done_hold", 32'(RC), 1);
    idle_inputs();
    tick();
    chk("done_release", 32'(RC), 0);

    // arm timeout
    St = 1; O5 = 1; O6 = 0;
    tick();
    n = 0;
    while (!R && n < 60) begin tick(); n++; end
    chk("arm_timeout", n, ARMT + 1);
    St = 0; O5 = 0;
    tick();
    chk("fault_release", 32'(R), 0);

    // early finish on wet soil
    enter_run();
    tick();
    Hraw = 1;
    n = 0;
    while (!H1 && n < 40) begin tick(); n++; end
    chk("deb_rise", n, DEBC + 1);
    chk("early_not_yet", 32'(RC), 0);
    tick();
    chk("early_done", 32'(RC), 1);
    idle_inputs();
    Hraw = 0;
    repeat (6) tick();
    chk("deb_fall", 32'(H1), 0);

    // debounce reject
    Hraw = 1;
    repeat (2) tick();
    Hraw = 0;
    repeat (5) begin
      tick();
      chk("deb_reject", 32'(H1), 0);
    end

    // pump drop mid-run
    enter_run();
    repeat (3) tick();
    O6 = 0;
    tick();
    chk("pump_drop_R",  32'(R),  1);
    chk("pump_drop_RC", 32'(RC), 0);
    idle_inputs();
    tick();
    chk("pump_drop_clr", 32'(R), 0);

    // reset mid-run, then a fresh sequence
    enter_run();
    repeat (4) tick();
    Clr = 1;
    tick();
    chk("midrst_RC", 32'(RC), 0);
    chk("midrst_R",  32'(R),  0);
    chk("midrst_H1", 32'(H1), 0);
    Clr = 0;
    idle_inputs();
    tick();
    enter_run();
    n = 0;
    while (!RC && n < 40) begin tick(); n++; end
    chk("rerun_len", n, RUNC);
    idle_inputs();
    tick();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      Clr = ($urandom_range(99) == 0);
      if ($urandom_range(7) == 0) St = ~St;
      if ($urandom_range(9) == 0) O5 = ~O5;
      if ($urandom_range(5) == 0) O6 = ~O6;
      if ($urandom_range(6) == 0) Hraw = ~Hraw;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
